// File: rtl/clint_timer.sv
// CLINT-style machine timer: prescaled 64-bit mtime, mtimecmp, registered compare interrupt,
// and a single-outstanding req/ack slave port (2-cycle throughput, one-cycle ack pulse).
module clint_timer #(
  parameter int          TICK_DIV     = 4,
  parameter logic [15:0] MTIME_OFF    = 16'hBFF8,
  parameter logic [15:0] MTIMECMP_OFF = 16'h4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic [63:0] mem_rdata,
  output logic        mem_ack,
  output logic [64:0] time_out
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [63:0]   mtime, mtimecmp, rdata, rdata_nxt, mask;
  logic          time_int;
  logic          tick, access, sel_time, sel_cmp, wr_time, wr_cmp;
  logic          unused_addr;

  assign unused_addr = ^{mem_addr[63:16], mem_addr[2:0]};

  assign tick     = (presc == PMAX);
  assign sel_time = (mem_addr[15:3] == MTIME_OFF[15:3]);
  assign sel_cmp  = (mem_addr[15:3] == MTIMECMP_OFF[15:3]);

  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{mem_wmask[i]}};
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: if (mem_req) begin
        access    = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An all-zero mask is a true no-op, so it must not suppress a pending tick.
  assign wr_time   = access & mem_we & sel_time & (|mem_wmask);
  assign wr_cmp    = access & mem_we & sel_cmp;
  assign rdata_nxt = sel_time ? mtime : (sel_cmp ? mtimecmp : 64'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      time_int <= 1'b0;
      rdata    <= '0;
    end else begin
      state    <= state_nxt;
      presc    <= tick ? '0 : presc + 1'b1;
      if (wr_time)   mtime <= (mtime & ~mask) | (mem_wdata & mask);
      else if (tick) mtime <= mtime + 64'd1;
      if (wr_cmp)    mtimecmp <= (mtimecmp & ~mask) | (mem_wdata & mask);
      time_int <= (mtime >= mtimecmp);
      if (access)    rdata <= rdata_nxt;
    end
  end

  assign mem_ack   = (state == ACK);
  assign mem_rdata = rdata;
  assign time_out  = {mtime, time_int};

endmodule

// File: tb/tb_clint_timer.sv
// Directed + randomized bench for clint_timer against a cycle-level behavioural model.
module tb_clint_timer;
  localparam int TD = 4;
  localparam logic [63:0] A_TIME = 64'h0200_BFF8;
  localparam logic [63:0] A_CMP  = 64'h0200_4000;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [63:0] mem_addr = '0, mem_wdata = '0;
  logic [7:0]  mem_wmask = '0;
  logic [63:0] mem_rdata, rdata1;
  logic        mem_ack, ack1;
  logic [64:0] time_out, time1;

  int checks = 0, errors = 0;

  clint_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .time_out(time_out));

  clint_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(1'b0), .mem_we(1'b0), .mem_addr(64'd0),
    .mem_wdata(64'd0), .mem_wmask(8'd0), .mem_rdata(rdata1),
    .mem_ack(ack1), .time_out(time1));

  always #5 clk = ~clk;

  // Reference model: cycle counter since reset drives the tick, registers updated per rules.
  longint unsigned m_cyc, m_time, m_cmp, m_rd;
  bit              m_tint, m_busy;

  function automatic longint unsigned merge(longint unsigned old_v, longint unsigned wd,
                                            logic [7:0] wm);
    longint unsigned r = old_v;
    for (int b = 0; b < 8; b++)
      if (wm[b]) r = (r & ~(64'hFF << (8*b))) | (wd & (64'hFF << (8*b)));
    return r;
  endfunction

  always @(posedge clk) begin
    longint unsigned ot, oc;
    bit tk, acc, ht, hc;
    if (!rst) begin
      m_cyc = 0; m_time = 0; m_cmp = ONES; m_rd = 0; m_tint = 0; m_busy = 0;
    end else begin
      ot = m_time; oc = m_cmp;
      tk = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_tint = (ot >= oc);
      acc = mem_req && !m_busy;
      ht = (mem_addr[15:0] & 16'hFFF8) == 16'hBFF8;
      hc = (mem_addr[15:0] & 16'hFFF8) == 16'h4000;
      if (acc) m_rd = ht ? ot : (hc ? oc : 0);
      if (acc && mem_we && ht && mem_wmask != 0) m_time = merge(ot, mem_wdata, mem_wmask);
      else if (tk) m_time = ot + 1;
      if (acc && mem_we && hc) m_cmp = merge(oc, mem_wdata, mem_wmask);
      m_busy = acc;
    end
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("time_out", time_out, {m_time, m_tint});
    chk("mem_ack", {64'd0, mem_ack}, {64'd0, m_busy});
    if (mem_ack) chk("mem_rdata", {1'b0, mem_rdata}, {1'b0, m_rd});
  endtask

  task automatic access(input logic we, input logic [63:0] a, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] rd);
    bit got = 0;
    mem_req = 1; mem_we = we; mem_addr = a; mem_wdata = wd; mem_wmask = wm;
    rd = '0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (mem_ack) begin got = 1; rd = mem_rdata; mem_req = 0; end
    end
    if (!got) begin chk("ack_timeout", 65'd0, 65'd1); mem_req = 0; end
  endtask

  logic [63:0] rd;
  int          acks;
  bit          prev_ack, found;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_time_out", time_out, 65'd0);
    chk("rst_ack", {64'd0, mem_ack}, 65'd0);
    chk("rst_rdata", {1'b0, mem_rdata}, 65'd0);
    chk("rst_time1", time1, 65'd0);

    // Count
    rst = 1;
    repeat (40) step();
    chk("count_div4", {1'b0, time_out[64:1]}, 65'd10);
    chk("count_div1", {1'b0, time1[64:1]}, 65'd40);
    access(0, A_CMP, 0, 0, rd);
    chk("rst_cmp_read", {1'b0, rd}, {1'b0, ONES});

    // Compare rise at mtime==cmp, fall after raising cmp
    access(1, A_TIME, 64'd0, 8'hFF, rd);
    access(1, A_CMP, 64'd5, 8'hFF, rd);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (time_out[64:1] == 64'd5) found = 1;
    end
    chk("reach_5", {64'd0, found}, 65'd1);
    chk("tint_lag", {64'd0, time_out[0]}, 65'd0);
    step();
    chk("tint_set", {64'd0, time_out[0]}, 65'd1);
    access(1, A_CMP, 64'd100, 8'hFF, rd);
    step();
    chk("tint_clear", {64'd0, time_out[0]}, 65'd0);

    // Wrap
    access(1, A_CMP, ONES, 8'hFF, rd);
    access(1, A_TIME, ONES, 8'hFF, rd);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (time_out[64:1] == 64'd0) found = 1;
    end
    chk("wrap_zero", {64'd0, found}, 65'd1);
    repeat (2) step();
    chk("wrap_tint_low", {64'd0, time_out[0]}, 65'd0);

    // Partial write, miss, held request
    access(1, A_CMP, 64'h1111_2222_3333_4444, 8'h0F, rd);
    access(0, A_CMP, 0, 0, rd);
    chk("partial_cmp", {1'b0, rd}, {1'b0, 64'hFFFF_FFFF_3333_4444});
    access(0, 64'h0, 0, 0, rd);
    chk("miss_read", {1'b0, rd}, 65'd0);
    mem_req = 1; mem_we = 0; mem_addr = A_TIME;
    acks = 0; prev_ack = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_ack) begin
        chk("ack_width", {64'd0, prev_ack}, 65'd0);
        acks++;
      end
      prev_ack = mem_ack;
    end
    mem_req = 0;
    chk("held_acks", 65'(acks), 65'd4);
    step();

    // Collision: mtime write accepted on a tick cycle
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if ((m_cyc % TD) == TD - 1) found = 1;
      else step();
    end
    access(1, A_TIME, 64'h1234, 8'hFF, rd);
    chk("collide_val", {1'b0, time_out[64:1]}, 65'h1234);
    repeat (3) step();
    chk("collide_hold", {1'b0, time_out[64:1]}, 65'h1234);
    step();
    chk("collide_next", {1'b0, time_out[64:1]}, 65'h1235);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [63:0] a, wd;
      case ($urandom_range(0, 2))
        0: a = A_TIME;
        1: a = A_CMP;
        default: a = {$urandom, $urandom};
      endcase
      wd = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 60));
      access($urandom_range(0, 1), a, wd, 8'($urandom), rd);
      repeat ($urandom_range(0, 5)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
